// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard plus branch wait/flush FSM gating issue; HAZARD_FWD_EN enables final-cycle bypass
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W = 5,
  parameter int MAX_LAT = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int LAT_W = $clog2(MAX_LAT + 1)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [REG_W-1:0]    i_rs1,
  input  logic                i_rs1_used,
  input  logic [REG_W-1:0]    i_rs2,
  input  logic                i_rs2_used,
  input  logic [REG_W-1:0]    i_rd,
  input  logic                i_wback,
  input  logic [LAT_W-1:0]    i_lat,
  input  logic                i_branch,
  input  logic                br_resolve,
  input  logic                br_taken,
  output logic                o_issue,
  output logic                o_stall,
  output logic                o_flush,
  output logic                o_fwd1,
  output logic                o_fwd2,
  output logic [NUM_REGS-1:0] o_busy
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {RUN, WAIT_BR, FLUSH} state_t;
  state_t state, state_nx;
  logic [FC_W-1:0] fc, fc_nx;
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] c1, c2, lat_sat;
  logic nr1, nr2, haz1, haz2, hazard;
  assign c1 = cnt[i_rs1];
  assign c2 = cnt[i_rs2];
  assign lat_sat = i_lat > LAT_W'(MAX_LAT) ? LAT_W'(MAX_LAT) : i_lat;
`ifdef HAZARD_FWD_EN
  assign nr1 = c1 > LAT_W'(1);
  assign nr2 = c2 > LAT_W'(1);
  assign o_fwd1 = o_issue && i_rs1_used && i_rs1 != '0 && c1 == LAT_W'(1);
  assign o_fwd2 = o_issue && i_rs2_used && i_rs2 != '0 && c2 == LAT_W'(1);
`else
  assign nr1 = c1 != '0;
  assign nr2 = c2 != '0;
  assign o_fwd1 = 1'b0;
  assign o_fwd2 = 1'b0;
`endif
  assign haz1 = i_rs1_used && i_rs1 != '0 && nr1;
  assign haz2 = i_rs2_used && i_rs2 != '0 && nr2;
  assign hazard = i_valid && (haz1 || haz2);
  always_comb begin
    state_nx = state;
    fc_nx = fc;
    o_issue = 1'b0;
    o_stall = 1'b0;
    o_flush = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          o_issue = i_valid && !hazard;
          o_stall = hazard;
          state_nx = o_issue && i_branch ? WAIT_BR : RUN;
        end
        WAIT_BR: begin
          o_stall = 1'b1;
          if (br_resolve) begin
            state_nx = br_taken ? FLUSH : RUN;
            fc_nx = FC_W'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          o_flush = 1'b1;
          state_nx = fc == '0 ? RUN : FLUSH;
          fc_nx = fc == '0 ? fc : fc - FC_W'(1);
        end
        default: state_nx = RUN;
      endcase
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
    assign o_busy[g] = !rst && cnt[g] != '0;
  end
  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    if (rst) begin
      state <= RUN;
      fc <= '0;
      for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      state <= state_nx;
      fc <= fc_nx;
      for (int r = 1; r < NUM_REGS; r++)
        cnt[r] <= (o_issue && i_wback && i_rd == REG_W'(r)) ? lat_sat :
                  cnt[r] != '0 ? cnt[r] - LAT_W'(1) : cnt[r];
    end
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit. It replaces per-stage wreg comparisons with a per-register countdown scoreboard, so any pipeline depth or writeback latency is handled by parameters and per-instruction latency.
- Adds a control-transfer FSM: wait for branch resolution, then issue a multi-cycle flush only when the branch is taken.
- Sits between decode and issue. It gates o_issue and drives stall/flush to fetch/decode.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never busy.
- REG_W, 5, register index width; must equal $clog2(NUM_REGS).
- MAX_LAT, 4, maximum issue-to-writeback latency in cycles; must be ≥1.
- FLUSH_CYCLES, 2, cycles o_flush is held after a taken branch; must be ≥1.
- LAT_W, $clog2(MAX_LAT+1), counter and i_lat width (derived).

Ports:
- clk in 1 clock
- rst in 1 synchronous active-high reset
- i_valid in 1 decode holds a valid instruction
- i_rs1 in REG_W source 1 index
- i_rs1_used in 1 instruction reads rs1
- i_rs2 in REG_W source 2 index
- i_rs2_used in 1 instruction reads rs2
- i_rd in REG_W destination index
- i_wback in 1 instruction writes rd
- i_lat in LAT_W cycles until rd is architecturally written
- i_branch in 1 instruction is Jal/Jalr/Branch
- br_resolve in 1 pulse: outstanding branch resolved
- br_taken in 1 qualifies br_resolve: redirect taken
- o_issue out 1 instruction accepted this cycle
- o_stall out 1 hold fetch/decode
- o_flush out 1 squash fetch/decode contents
- o_fwd1 out 1 rs1 must take bypass value
- o_fwd2 out 1 rs2 must take bypass value
- o_busy out NUM_REGS per-register pending mask (bit r = cnt[r]!=0)

Behaviour:
- State: cnt[r] (LAT_W bits, r=1..NUM_REGS-1; cnt[0] hard-wired 0), FSM {RUN, WAIT_BR, FLUSH}, flush counter.
- Reset (synchronous):
  - All cnt cleared, FSM to RUN, flush counter 0.
  - All outputs 0 while rst is high, including o_busy.
  - Reset mid-WAIT_BR/FLUSH abandons the operation without a flush pulse.
- Source hazard:
  - srcN_haz = srcN_used && rsN!=0 && not_ready(cnt[rsN]).
  - not_ready(c) = (c!=0) without the optional feature.
  - hazard = i_valid && (src1_haz || src2_haz).
- RUN:
  - o_issue = i_valid && !hazard.
  - o_stall = hazard.
  - o_flush = 0.
  - If o_issue && i_branch, go to WAIT_BR next cycle.
  - br_resolve in RUN is ignored.
- WAIT_BR:
  - o_issue = 0, o_stall = 1, o_flush = 0.
  - On br_resolve with br_taken=1: go to FLUSH and load flush counter = FLUSH_CYCLES-1.
  - On br_resolve with br_taken=0: go to RUN.
  - Otherwise stay.
- FLUSH:
  - o_flush = 1, o_stall = 0, o_issue = 0; the decode input is treated as a bubble.
  - Counter decrements each cycle; at 0 go to RUN.
  - o_flush is therefore high for exactly FLUSH_CYCLES cycles.
- Scoreboard update, every cycle:
  - Each nonzero cnt decrements by 1.
  - If o_issue && i_wback && i_rd!=0: cnt[i_rd] <= min(i_lat, MAX_LAT). This overrides that register's decrement in the same cycle.
  - i_lat=0 leaves the register not busy.
- Same-cycle read and write: an instruction with rs1==rd is checked against the old cnt; its own write does not stall itself.
- Scoreboard counters keep decrementing in all FSM states.
- o_busy is a combinational view of registered cnt.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined:
  - not_ready(c) = (c > 1); a producer in its final cycle (cnt==1) is bypassed.
  - o_fwdN = i_valid && srcN_used && rsN!=0 && cnt[rsN]==1 && o_issue.
- Undefined:
  - not_ready(c) = (c != 0).
  - o_fwd1 and o_fwd2 tied to 0; the ports still exist.

Test Plan (MAX_LAT=4, FLUSH_CYCLES=2):
- Issue rd=5, lat=3, wback at cycle 0; next instruction rs1=5 valid from cycle 1 -> o_stall=1 cycles 1–3, o_issue=1 at cycle 4. With HAZARD_FWD_EN: stall cycles 1–2, issue at cycle 3 with o_fwd1=1.
- Issue rd=0, lat=4; next instruction rs1=0, rs2=0 used -> no stall, o_busy stays 0.
- Branch issued at cycle 0; br_resolve=1, br_taken=1 at cycle 3 -> o_stall=1 cycles 1–3, o_flush=1 cycles 4–5, o_issue possible at cycle 6.
- Branch issued at cycle 0; br_resolve=1, br_taken=0 at cycle 2 -> o_stall cycles 1–2, o_flush never asserts, RUN at cycle 3.
- Issue rd=7, i_lat=7 (saturates to MAX_LAT) -> o_busy[7] high for exactly 4 cycles; a reissue of rd=7 lat=1 at the second cycle reloads cnt[7] to 1.
- Assert rst during FLUSH with registers 3 and 9 busy -> next cycle o_flush=0, o_stall=0, o_busy=0, FSM in RUN.
